// File: rtl/buzzer_pkg.sv
// ----------------------------------------------------------------------------
// buzzer_pkg : shared beep patterns, pattern record and sequencer state type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package buzzer_pkg;

  typedef struct packed {
    logic [19:0] tone;
    logic [9:0]  on_ms;
    logic [9:0]  off_ms;
    logic [3:0]  count;
  } pattern_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [19:0] DEFAULT_TONE = 20'd191_110;
  localparam int          NUM_PATTERNS = 3;

  localparam pattern_t PATTERNS [NUM_PATTERNS] = '{
    '{20'd1000, 10'd3, 10'd2, 4'd2},
    '{20'd2000, 10'd1, 10'd0, 4'd1},
    '{20'd1500, 10'd1, 10'd0, 4'd3}
  };

  // Sources without a table entry fall back to a single short default beep.
  function automatic pattern_t get_pattern(input int idx);
    pattern_t p;
    p = '{DEFAULT_TONE, 10'd1, 10'd0, 4'd1};
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (idx == i) p = PATTERNS[i];
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/buzzer_tick_gen.sv
// ----------------------------------------------------------------------------
// buzzer_tick_gen : TICK_DIV prescaler with synchronous clear, 1-cycle tick
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module buzzer_tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clear || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/buzzer_sequencer.sv
// ----------------------------------------------------------------------------
// buzzer_sequencer : priority-arbitrated beep pattern player (BUZZER_PREEMPT_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int TICK_DIV = 50_000,
  parameter int GAP_MS   = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               done,
  output logic               busy,
  output logic               buzzer_en,
  output logic [19:0]        tone_cycle
);

  localparam logic [15:0] GAP_TARGET = (GAP_MS < 1) ? 16'd1 : 16'(GAP_MS);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  pattern_t           pat_q, pat_d;
  logic [3:0]         beep_q, beep_d;
  logic [15:0]        ms_q, ms_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               done_q, done_d;
  logic               buzzer_en_q, buzzer_en_d;

  logic               tick;
  logic               tick_clear;
  logic               preempt;
  logic               restart;
  logic               grant;
  int                 grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [9:0]         eff_on;
  logic [3:0]         eff_count;
  logic [15:0]        phase_target;
  logic               phase_done;

  buzzer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .i_clear (tick_clear),
    .o_tick  (tick)
  );

`ifdef BUZZER_PREEMPT_EN
  logic [NUM_REQ-1:0] active_q;

  always_ff @(posedge clk) begin
    if (reset)             active_q <= '0;
    else if (ack_d != '0)  active_q <= ack_d;
  end

  // active_q is one-hot, so subtracting one yields the mask of higher-priority sources.
  assign preempt = (pending_q & (active_q - NUM_REQ'(1))) != '0;
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | req;
    pat_d       = pat_q;
    beep_d      = beep_q;
    ms_d        = ms_q + {15'd0, tick};
    ack_d       = '0;
    done_d      = 1'b0;
    buzzer_en_d = buzzer_en_q;
    restart     = 1'b0;
    grant       = 1'b0;
    grant_idx   = 0;
    grant_oh    = '0;

    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_idx   = i;
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end

    eff_on    = (pat_q.on_ms == 10'd0) ? 10'd1 : pat_q.on_ms;
    eff_count = (pat_q.count == 4'd0)  ? 4'd1  : pat_q.count;

    case (state_q)
      ON:      phase_target = {6'd0, eff_on};
      OFF:     phase_target = {6'd0, pat_q.off_ms};
      GAP:     phase_target = GAP_TARGET;
      default: phase_target = 16'd1;
    endcase
    phase_done = tick && (ms_q == phase_target - 16'd1);

    case (state_q)
      IDLE: grant = (pending_q != '0);
      ON: begin
        if (phase_done) begin
          if (({1'b0, beep_q} + 5'd1) < {1'b0, eff_count}) begin
            beep_d = beep_q + 4'd1;
            if (pat_q.off_ms == 10'd0) begin
              restart = 1'b1;
            end else begin
              state_d     = OFF;
              buzzer_en_d = 1'b0;
            end
          end else begin
            state_d     = GAP;
            buzzer_en_d = 1'b0;
          end
        end
      end
      OFF: begin
        if (phase_done) begin
          state_d     = ON;
          buzzer_en_d = 1'b1;
        end
      end
      GAP: begin
        if (phase_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
          grant   = (pending_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase

    if (((state_q == ON) || (state_q == OFF)) && preempt) begin
      state_d     = IDLE;
      buzzer_en_d = 1'b0;
      restart     = 1'b0;
      beep_d      = beep_q;
    end

    // A request arriving in the grant cycle keeps its pending bit, so it replays.
    if (grant) begin
      state_d     = ON;
      ack_d       = grant_oh;
      pending_d   = (pending_q & ~grant_oh) | req;
      pat_d       = get_pattern(grant_idx);
      buzzer_en_d = 1'b1;
      beep_d      = 4'd0;
    end

    tick_clear = (state_d != state_q) || restart;
    if (tick_clear) ms_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      pat_q       <= '{DEFAULT_TONE, 10'd0, 10'd0, 4'd0};
      beep_q      <= '0;
      ms_q        <= '0;
      ack_q       <= '0;
      done_q      <= 1'b0;
      buzzer_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pat_q       <= pat_d;
      beep_q      <= beep_d;
      ms_q        <= ms_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      buzzer_en_q <= buzzer_en_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign buzzer_en  = buzzer_en_q;
  assign tone_cycle = pat_q.tone;

endmodule

`default_nettype wire
